// File: rtl/bs_pipe_shifter.sv
// Pipelined barrel shifter/rotator.
// One register stage per shift-amount bit: stage k applies a move of 2^k
// positions when bit k of the word's captured amount is set. Every stage carries
// its word's mode and the operand MSB, so words with different modes can be
// in flight together.
//
// Handshake: a word moves on any edge where its valid is 1 and the receiver's
// ready is 1 (i_valid & o_ready upstream, o_valid & i_ready downstream).
// Valid does not depend on ready.
// While o_valid = 1 and i_ready = 0 the whole pipe holds, so o_Y and o_valid
// stay stable and o_ready drops.
`timescale 1ns/1ps

module bs_pipe_shifter #(
   parameter int WIDTH = 8,
   parameter int SW    = $clog2(WIDTH)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_X,
   input  logic [SW-1:0]    i_shamt,
   input  logic             i_shift,
   input  logic             i_left,
   input  logic             i_arith,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_Y,
   output logic             o_busy
);

   // One stage's move of amt positions. A rotate refills the vacated end from the
   // bits leaving the other end. A left or logical shift fills with 0. An
   // arithmetic right shift fills with the operand MSB latched at entry.
   function automatic logic [WIDTH-1:0] stage_op(
      input logic [WIDTH-1:0] x,
      input int unsigned      amt,
      input logic             en,
      input logic             shift,
      input logic             left,
      input logic             arith,
      input logic             msb
   );
      logic [WIDTH-1:0] r;
      r = x;
      if (en) begin
         if (!shift) begin
            if (left) r = (x << amt) | (x >> (WIDTH - amt));
            else      r = (x >> amt) | (x << (WIDTH - amt));
         end else if (left) begin
            r = x << amt;
         end else begin
            r = x >> amt;
            if (arith && msb) r = r | ~({WIDTH{1'b1}} >> amt);
         end
      end
      return r;
   endfunction

   // Stage registers. The last stage drives the outputs.
   logic [SW-1:0]    valid_q;
   logic [WIDTH-1:0] data_q  [SW];
   logic [SW-1:0]    shamt_q [SW];
   logic             shift_q [SW];
   logic             left_q  [SW];
   logic             arith_q [SW];
   logic             msb_q   [SW];

   // Values that will load into each stage on the next advance.
   logic [SW-1:0]    valid_d;
   logic [WIDTH-1:0] data_d  [SW];
   logic [SW-1:0]    shamt_d [SW];
   logic             shift_d [SW];
   logic             left_d  [SW];
   logic             arith_d [SW];
   logic             msb_d   [SW];

   logic advance;

   // The whole pipe moves as one unit unless the output word is blocked.
   assign advance = ~o_valid | i_ready;
   assign o_ready = advance;
   assign o_valid = valid_q[SW-1];
   assign o_Y     = data_q[SW-1];
   assign o_busy  = |valid_q;

   for (genvar k = 0; k < SW; k++) begin : g_stage
      logic [WIDTH-1:0] src_x;
      logic [SW-1:0]    src_sh;
      logic             src_v;
      logic             src_shift;
      logic             src_left;
      logic             src_arith;
      logic             src_msb;

      if (k == 0) begin : g_entry
         // The first stage takes the incoming word and latches its MSB for sign fill.
         assign src_v     = i_valid;
         assign src_x     = i_X;
         assign src_sh    = i_shamt;
         assign src_shift = i_shift;
         assign src_left  = i_left;
         assign src_arith = i_arith;
         assign src_msb   = i_X[WIDTH-1];
      end else begin : g_chain
         assign src_v     = valid_q[k-1];
         assign src_x     = data_q[k-1];
         assign src_sh    = shamt_q[k-1];
         assign src_shift = shift_q[k-1];
         assign src_left  = left_q[k-1];
         assign src_arith = arith_q[k-1];
         assign src_msb   = msb_q[k-1];
      end

      assign valid_d[k] = src_v;
      assign data_d[k]  = stage_op(src_x, 1 << k, src_sh[k], src_shift,
                                   src_left, src_arith, src_msb);
      assign shamt_d[k] = src_sh;
      assign shift_d[k] = src_shift;
      assign left_d[k]  = src_left;
      assign arith_d[k] = src_arith;
      assign msb_d[k]   = src_msb;
   end

   // Advance all stages together. A bubble moves only its valid bit, and the
   // payload of a bubble stage keeps its old, don't-care contents.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         valid_q <= '0;
         for (int k = 0; k < SW; k++) begin
            data_q[k]  <= '0;
            shamt_q[k] <= '0;
            shift_q[k] <= 1'b0;
            left_q[k]  <= 1'b0;
            arith_q[k] <= 1'b0;
            msb_q[k]   <= 1'b0;
         end
      end else if (advance) begin
         valid_q <= valid_d;
         for (int k = 0; k < SW; k++) begin
            if (valid_d[k]) begin
               data_q[k]  <= data_d[k];
               shamt_q[k] <= shamt_d[k];
               shift_q[k] <= shift_d[k];
               left_q[k]  <= left_d[k];
               arith_q[k] <= arith_d[k];
               msb_q[k]   <= msb_d[k];
            end
         end
      end
   end

endmodule

// File: tb/tb_bs_pipe_shifter.sv
// Directed bench for bs_pipe_shifter (WIDTH = 8, SW = 3), plus a full operand
// sweep against a shift/rotate reference model with random handshake gaps.
`timescale 1ns/1ps

module tb_bs_pipe_shifter;
   localparam int WIDTH = 8;
   localparam int SW    = 3;
   localparam int NWORDS = 256 * 8 * 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             i_valid;
   logic             o_ready;
   logic [WIDTH-1:0] i_X;
   logic [SW-1:0]    i_shamt;
   logic             i_shift;
   logic             i_left;
   logic             i_arith;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_Y;
   logic             o_busy;

   int checks = 0;
   int errors = 0;
   logic [WIDTH-1:0] exp_q[$];

   bs_pipe_shifter #(.WIDTH(WIDTH), .SW(SW)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_X     (i_X),
      .i_shamt (i_shamt),
      .i_shift (i_shift),
      .i_left  (i_left),
      .i_arith (i_arith),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_Y     (o_Y),
      .o_busy  (o_busy)
   );

   // Clock and reset
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Driver tasks
   task automatic drive(input logic [7:0] x, input logic [2:0] sh,
                        input logic s, input logic l, input logic a);
      i_X = x; i_shamt = sh; i_shift = s; i_left = l; i_arith = a;
   endtask

   // Offer one word into an empty pipe, then check latency and result.
   task automatic single(input string tag, input logic [7:0] x, input logic [2:0] sh,
                         input logic s, input logic l, input logic a, input logic [7:0] exp);
      int n;
      drive(x, sh, s, l, a);
      i_valid = 1'b1;
      i_ready = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      n = 0;
      while (!o_valid && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_valid"}, o_valid, 1);
      chk({tag, "_lat"}, n, 2);
      chk(tag, o_Y, exp);
      @(posedge clk); #1;
   endtask

   // Reference model: rotate via a doubled word, arithmetic via signed shift.
   function automatic logic [7:0] ref_model(input logic [7:0] x, input int sh,
                                            input logic s, input logic l, input logic a);
      logic [15:0]       dbl;
      logic signed [7:0] sx;
      dbl = {x, x};
      sx  = x;
      if (!s) begin
         if (l) begin dbl = dbl << sh; return dbl[15:8]; end
         dbl = dbl >> sh;
         return dbl[7:0];
      end
      if (l) return x << sh;
      if (a) return sx >>> sh;
      return x >> sh;
   endfunction

   logic [7:0] w_in  [6] = '{8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76};
   logic [7:0] w_exp [6] = '{8'h12, 8'h23, 8'h34, 8'h45, 8'h56, 8'h67};

   initial begin
      int idx, oidx, n, sent;
      logic acc, take;
      logic [7:0] held, ev;

      rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
      drive(8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
      #12;
      chk("rst_valid", o_valid, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_y", o_Y, 0);
      chk("rst_ready", o_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      #1;

      // Single words: latency and the mode table
      single("rotl_81_1",  8'h81, 3'd1, 1'b0, 1'b1, 1'b0, 8'h03);
      single("lsr_80_7",   8'h80, 3'd7, 1'b1, 1'b0, 1'b0, 8'h01);
      single("asr_80_3",   8'h80, 3'd3, 1'b1, 1'b0, 1'b1, 8'hF0);
      single("asl_81_1",   8'h81, 3'd1, 1'b1, 1'b1, 1'b1, 8'h02);
      single("asr_70_2",   8'h70, 3'd2, 1'b1, 1'b0, 1'b1, 8'h1C);
      single("rotr_81_3",  8'h81, 3'd3, 1'b0, 1'b0, 1'b0, 8'h30);
      single("asr_c3_5",   8'hC3, 3'd5, 1'b1, 1'b0, 1'b1, 8'hFE);
      single("asr_a5_0",   8'hA5, 3'd0, 1'b1, 1'b0, 1'b1, 8'hA5);
      single("rotl_a5_0",  8'hA5, 3'd0, 1'b0, 1'b1, 1'b0, 8'hA5);

      // Back-to-back rotate-left of 0x01 by 0..7
      for (int c = 0; c < 10; c++) begin
         if (c < 8) begin
            drive(8'h01, c[2:0], 1'b0, 1'b1, 1'b0);
            i_valid = 1'b1;
         end else begin
            i_valid = 1'b0;
         end
         @(posedge clk); #1;
         if (c >= 2) begin
            chk("b2b_valid", o_valid, 1);
            chk("b2b_y", o_Y, 64'h1 << (c - 2));
         end
      end
      @(posedge clk); #1;
      chk("b2b_drain", o_valid, 0);

      // Stall: downstream blocks for 4 cycles while upstream keeps offering
      idx = 0; oidx = 0; held = '0;
      for (int c = 0; c < 40; c++) begin
         i_ready = !(c >= 4 && c < 8);
         if (idx < 6) begin
            drive(w_in[idx], 3'd4, 1'b0, 1'b1, 1'b0);
            i_valid = 1'b1;
         end else begin
            i_valid = 1'b0;
         end
         #1;
         if (c >= 4 && c < 8) begin
            chk("stall_ready", o_ready, 0);
            chk("stall_valid", o_valid, 1);
            if (c == 4) held = o_Y;
            else chk("stall_y", o_Y, held);
         end
         acc  = i_valid && o_ready;
         take = o_valid && i_ready;
         if (take) begin
            if (oidx < 6) chk("stall_out", o_Y, w_exp[oidx]);
            oidx++;
         end
         @(posedge clk); #1;
         if (acc) idx++;
      end
      chk("stall_count", oidx, 6);
      chk("stall_idle_busy", o_busy, 0);
      i_ready = 1'b1;

      // Asynchronous reset with three words in flight
      for (int i = 0; i < 3; i++) begin
         drive(8'h3C + 8'(i), 3'd0, 1'b0, 1'b1, 1'b0);
         i_valid = 1'b1;
         @(posedge clk); #1;
      end
      i_valid = 1'b0;
      i_ready = 1'b0;
      chk("prerst_valid", o_valid, 1);
      chk("prerst_busy", o_busy, 1);
      chk("prerst_y", o_Y, 8'h3C);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid", o_valid, 0);
      chk("arst_busy", o_busy, 0);
      chk("arst_y", o_Y, 0);
      chk("arst_ready", o_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      i_ready = 1'b1;
      chk("postrst_valid", o_valid, 0);
      drive(8'h5A, 3'd1, 1'b0, 1'b0, 1'b0);
      i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      n = 0;
      while (!o_valid && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk("postrst_lat", n, 2);
      chk("postrst_y", o_Y, 8'h2D);
      @(posedge clk); #1;
      chk("postrst_drain", o_valid, 0);

      // Every operand x amount x mode against the model, random gaps
      sent = 0;
      for (int cyc = 0; cyc < 90000 && (sent < NWORDS || exp_q.size() != 0); cyc++) begin
         i_ready = ($urandom_range(0, 3) != 0);
         if (sent < NWORDS && $urandom_range(0, 3) != 0) begin
            drive(sent[7:0], sent[10:8], sent[11], sent[12], sent[13]);
            i_valid = 1'b1;
         end else begin
            i_valid = 1'b0;
         end
         #1;
         if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
               chk("sweep_spurious", o_valid, 0);
            end else begin
               ev = exp_q.pop_front();
               chk("sweep", o_Y, ev);
            end
         end
         if (i_valid && o_ready) begin
            exp_q.push_back(ref_model(sent[7:0], int'(sent[10:8]), sent[11], sent[12], sent[13]));
            sent++;
         end
         @(posedge clk); #1;
      end
      chk("sweep_sent", sent, NWORDS);
      chk("sweep_drain", exp_q.size(), 0);

      // Final report
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bs_pipe_shifter.md
BS_PIPE_SHIFTER -- requirements
Module: bs_pipe_shifter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data width; legal values are powers of two, 4 to 64.
REQ-002 The block SHALL have parameter SW, default $clog2(WIDTH), meaning shift-amount width and pipeline depth.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port i_valid, input, 1 bit: the input word is offered.
REQ-006 The block SHALL have port o_ready, output, 1 bit: the block accepts the input word this cycle.
REQ-007 The block SHALL have port i_X, input, WIDTH bits: the operand.
REQ-008 The block SHALL have port i_shamt, input, SW bits: the shift/rotate amount, 0 to WIDTH-1.
REQ-009 The block SHALL have port i_shift, input, 1 bit: 1 = shift, 0 = rotate.
REQ-010 The block SHALL have port i_left, input, 1 bit: 1 = left, 0 = right.
REQ-011 The block SHALL have port i_arith, input, 1 bit: 1 = arithmetic; it has effect only for a right shift.
REQ-012 The block SHALL have port o_valid, output, 1 bit: o_Y holds a result.
REQ-013 The block SHALL have port i_ready, input, 1 bit: downstream accepts o_Y.
REQ-014 The block SHALL have port o_Y, output, WIDTH bits: the result.
REQ-015 The block SHALL have port o_busy, output, 1 bit: at least one pipeline stage holds a valid word.

Function
REQ-016 The pipeline SHALL have SW register stages; stage k (k = 0..SW-1) moves by 2^k positions when bit k of the stage's captured shamt is 1, and passes the word unchanged otherwise.
REQ-017 Each stage SHALL register data, valid, remaining shamt bits, shift, left, arith, and the operand MSB captured at entry.
REQ-018 For a rotate, the bits vacated at one end SHALL be refilled from the bits leaving the opposite end.
REQ-019 For a logical shift, and for any left shift, the vacated bits SHALL be 0.
REQ-020 For an arithmetic right shift, the vacated bits SHALL equal the captured operand MSB.
REQ-021 The sign-extension fill SHALL use the original i_X[WIDTH-1] latched at entry, not the intermediate stage data.
REQ-022 Latency SHALL be exactly SW cycles from acceptance (i_valid & o_ready at an edge) to o_valid, when no stall occurs.
REQ-023 The advance condition SHALL be advance = ~o_valid | i_ready.
REQ-024 All stages SHALL shift forward together when advance = 1 and hold all contents when advance = 0.
REQ-025 o_ready SHALL equal advance and SHALL be purely combinational from o_valid and i_ready.
REQ-026 When advance = 1 and i_valid = 0, a bubble (valid = 0) SHALL enter stage 0.
REQ-027 Bubbles SHALL NOT be collapsed; throughput SHALL be one word per cycle while i_ready = 1.
REQ-028 While o_valid = 1 and i_ready = 0, o_Y and o_valid SHALL remain stable.
REQ-029 i_shamt = 0 SHALL return i_X unchanged in all modes.
REQ-030 Modes SHALL be captured per word; a mode change between consecutive words SHALL NOT affect words already in flight.
REQ-031 o_busy SHALL be the OR of all stage valid bits.
REQ-032 Data and control registers of bubble stages SHALL hold their previous contents, which are don't-care; only valid bits are observable.

Reset
REQ-033 Assertion of i_rst SHALL immediately clear all stage valid bits, o_valid, and o_busy, independent of i_clk.
REQ-034 Assertion of i_rst SHALL set o_Y to 0 and all stage data registers to 0.
REQ-035 Reset mid-operation SHALL discard all in-flight words; none SHALL appear after deassertion.
REQ-036 o_ready SHALL be 1 during and after reset, because o_valid = 0.
REQ-037 The first edge after i_rst deassertion SHALL be able to accept a word.

Verification (WIDTH = 8, SW = 3)
REQ-038 Rotate-left check: i_X = 0x81, i_shamt = 1, shift = 0, left = 1 -> o_Y = 0x03 with o_valid exactly 3 cycles after acceptance.
REQ-039 Shift checks: logical right 0x80 by 7 -> 0x01; arithmetic right 0x80 by 3 -> 0xF0; arithmetic left 0x81 by 1 -> 0x02; arithmetic right 0x70 by 2 -> 0x1C.
REQ-040 Back-to-back check: 8 words on consecutive cycles with i_ready = 1, i_X = 0x01, i_shamt = 0..7, rotate left -> o_Y = 0x01, 0x02, ..., 0x80 on 8 consecutive cycles.
REQ-041 Stall check: hold i_ready = 0 for 4 cycles while o_valid = 1 -> o_Y stable and o_ready = 0; upstream words held, none lost or duplicated after release.
REQ-042 Reset check: assert i_rst asynchronously with 3 words in flight -> o_valid = 0, o_busy = 0, o_Y = 0 at once; no stale output after release.
REQ-043 Exhaustive check: all 256 operands x 8 amounts x all modes SHALL be compared against a reference model with random i_valid/i_ready gaps.
